// File: rtl/core_mem_pkg.sv
// Shared constants and decode helpers for core_mem_responder.
// Bank 2 (output FIFO) is present only when CORE_MEM_FIFO_EN is defined.
package core_mem_pkg;

    // Bank byte values (Address[23:16])
    localparam logic [7:0] BANK_RAM  = 8'h00;
    localparam logic [7:0] BANK_GPIO = 8'h01;
    localparam logic [7:0] BANK_FIFO = 8'h02;
    localparam logic [7:0] BANK_CNT  = 8'h03;

    // Word offsets within each bank (Address[15:0])
    localparam logic [15:0] OFF_GPIO_OUT  = 16'h0000;
    localparam logic [15:0] OFF_GPIO_IN   = 16'h0001;
    localparam logic [15:0] OFF_FIFO_DATA = 16'h0000;
    localparam logic [15:0] OFF_FIFO_STAT = 16'h0001;
    localparam logic [15:0] OFF_CNT_LO    = 16'h0000;
    localparam logic [15:0] OFF_CNT_HI    = 16'h0001;

    // FIFO status word layout
    localparam int ST_FULL     = 7;
    localparam int ST_EMPTY    = 6;
    localparam int ST_DROP_LSB = 8;
    localparam int ST_OCC_W    = 6;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_GPIO,
        SEL_FIFO,
        SEL_CNT,
        SEL_NONE
    } bank_sel_e;

    // One bus cycle as seen by the responder
    typedef struct packed {
        logic [7:0]  bank;
        logic [15:0] off;
        logic [15:0] wdata;
        logic        we;
    } bus_req_t;

    // Map the bank byte onto a select; the caller decides whether FIFO is mapped.
    function automatic bank_sel_e decode_bank(input logic [7:0] bank, input logic fifo_mapped);
        bank_sel_e sel;
        case (bank)
            BANK_RAM:  sel = SEL_RAM;
            BANK_GPIO: sel = SEL_GPIO;
            BANK_FIFO: sel = fifo_mapped ? SEL_FIFO : SEL_NONE;
            BANK_CNT:  sel = SEL_CNT;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/core_out_fifo.sv
// Parameterised synchronous FIFO with asynchronous active-high reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head word reads as 0 whenever the FIFO is empty, so reset clears it
// immediately without touching the storage.
module core_out_fifo #(
    parameter int AW = 3,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage is written only on accepted pushes; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Pointer update; wrap is natural modulo 2^(AW+1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the 16-bit core bus: RAM, GPIO, output FIFO and
// a 32-bit cycle counter, selected by Address[23:16].
// Define CORE_MEM_FIFO_EN to map the output FIFO in bank 2; otherwise bank 2
// is unmapped and the drain port is tied off.
module core_mem_responder
    import core_mem_pkg::*;
#(
    parameter int RAM_AW  = 10,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] Address,
    input  logic [15:0] WriteData,
    input  logic        WriteEnable,
    output logic [15:0] ReadData,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    bus_req_t  req;
    bank_sel_e sel;

    assign req.bank  = Address[23:16];
    assign req.off   = Address[15:0];
    assign req.wdata = WriteData;
    assign req.we    = WriteEnable;

`ifdef CORE_MEM_FIFO_EN
    assign sel = decode_bank(req.bank, 1'b1);
`else
    assign sel = decode_bank(req.bank, 1'b0);
`endif

    // ---------------- Bank 0: RAM ----------------
    logic [15:0] ram [2 ** RAM_AW];
    logic [15:0] ram_rd;

    // Upper offset bits are ignored, so the RAM aliases across the bank.
    assign ram_rd = ram[req.off[RAM_AW-1:0]];

    // RAM write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (req.we && sel == SEL_RAM)
            ram[req.off[RAM_AW-1:0]] <= req.wdata;
    end

    // ---------------- Bank 1: GPIO ----------------
    logic [15:0] gpio_s1;
    logic [15:0] gpio_s2;

    // Two-flop synchronizer on the board inputs plus the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_s1  <= '0;
            gpio_s2  <= '0;
            gpio_out <= '0;
        end else begin
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
            if (req.we && sel == SEL_GPIO && req.off == OFF_GPIO_OUT)
                gpio_out <= req.wdata;
        end
    end

    // ---------------- Bank 3: cycle counter ----------------
    logic [31:0] cycle_cnt;

    // Free-running counter; a write to the low word restarts it from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cycle_cnt <= '0;
        else if (req.we && sel == SEL_CNT && req.off == OFF_CNT_LO)
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    // ---------------- Bank 2: output FIFO ----------------
`ifdef CORE_MEM_FIFO_EN
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_AW:0]   fifo_count;
    logic               push_req;
    logic               pop;
    logic               push_ok;
    logic [7:0]         drop_cnt;
    logic [15:0]        fifo_status;

    assign push_req  = req.we && sel == SEL_FIFO && req.off == OFF_FIFO_DATA;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = push_req && (!fifo_full || pop);

    core_out_fifo #(
        .AW (FIFO_AW),
        .W  (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (req.wdata),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Saturating count of rejected pushes; any write to status clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt <= '0;
        else if (req.we && sel == SEL_FIFO && req.off == OFF_FIFO_STAT)
            drop_cnt <= '0;
        else if (push_req && !push_ok && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

    // Status word: drop count, full, empty, zero-extended occupancy.
    always_comb begin
        fifo_status                             = '0;
        fifo_status[ST_DROP_LSB +: 8]           = drop_cnt;
        fifo_status[ST_FULL]                    = fifo_full;
        fifo_status[ST_EMPTY]                   = fifo_empty;
        fifo_status[ST_OCC_W-1:0]               = ST_OCC_W'(fifo_count);
    end
`else
    logic unused_out_ready;

    assign unused_out_ready = out_ready;
    assign out_valid        = 1'b0;
    assign out_data         = '0;
`endif

    // ---------------- Read mux ----------------
    // Combinational read of the addressed location; writes land at the edge,
    // so a same-cycle read returns the old value.
    always_comb begin
        ReadData = '0;
        case (sel)
            SEL_RAM: ReadData = ram_rd;
            SEL_GPIO: begin
                if (req.off == OFF_GPIO_OUT)     ReadData = gpio_out;
                else if (req.off == OFF_GPIO_IN) ReadData = gpio_s2;
            end
`ifdef CORE_MEM_FIFO_EN
            SEL_FIFO: begin
                if (req.off == OFF_FIFO_STAT) ReadData = fifo_status;
            end
`endif
            SEL_CNT: begin
                if (req.off == OFF_CNT_LO)      ReadData = cycle_cnt[15:0];
                else if (req.off == OFF_CNT_HI) ReadData = cycle_cnt[31:16];
            end
            default: ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_core_mem_responder.sv
// Self-checking bench for core_mem_responder. FIFO checks run only when
// CORE_MEM_FIFO_EN is defined; otherwise the tied-off bank 2 is checked.
module tb_core_mem_responder;

    localparam int RAM_AW  = 10;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 2 ** FIFO_AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] Address;
    logic [15:0] WriteData;
    logic        WriteEnable;
    logic [15:0] ReadData;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    core_mem_responder #(
        .RAM_AW  (RAM_AW),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Address     (Address),
        .WriteData   (WriteData),
        .WriteEnable (WriteEnable),
        .ReadData    (ReadData),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One write cycle; returns at the falling edge after the write edge.
    task automatic wr(input logic [23:0] a, input logic [15:0] d);
        @(negedge clk);
        Address     = a;
        WriteData   = d;
        WriteEnable = 1'b1;
        @(negedge clk);
        WriteEnable = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [23:0] a, input logic [15:0] exp);
        Address = a;
        #1;
        chk(tag, ReadData, exp);
    endtask

    // Drain the scoreboard through the handshake, bounded by a cycle budget.
    task automatic drain(input string tag);
        int budget = 40;
        out_ready = 1'b1;
        while (sb.size() > 0 && budget > 0) begin
            #1;
            if (out_valid) chk(tag, out_data, sb.pop_front());
            @(negedge clk);
            budget--;
        end
        chk({tag, "_left"}, 16'(sb.size()), 16'd0);
        #1;
        chk({tag, "_valid_low"}, {15'd0, out_valid}, 16'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int occ_m;
        int drops_m;

        reset       = 1'b1;
        Address     = '0;
        WriteData   = '0;
        WriteEnable = 1'b0;
        gpio_in     = '0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gpio_out", gpio_out, 16'h0000);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", out_data, 16'h0000);
        rd("rst_gpio_in", 24'h010001, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // RAM write/read and aliasing
        wr(24'h000005, 16'hBEEF);
        sb.push_back(16'hBEEF);
        rd("ram_rd", 24'h000005, sb.pop_front());
        rd("ram_alias", 24'h000405, 16'hBEEF);

        // Read during write returns old data, new data next cycle
        @(negedge clk);
        Address     = 24'h000005;
        WriteData   = 16'h1234;
        WriteEnable = 1'b1;
        #1;
        chk("ram_rdw_old", ReadData, 16'hBEEF);
        @(negedge clk);
        WriteEnable = 1'b0;
        #1;
        chk("ram_rdw_new", ReadData, 16'h1234);
        rd("ram_alias2", 24'h00FC05, 16'h1234);

        // GPIO
        wr(24'h010000, 16'h00A5);
        #1;
        chk("gpio_out", gpio_out, 16'h00A5);
        rd("gpio_out_rd", 24'h010000, 16'h00A5);
        gpio_in = 16'h1234;
        rd("gpio_sync0", 24'h010001, 16'h0000);
        @(negedge clk);
        rd("gpio_sync1", 24'h010001, 16'h0000);
        @(negedge clk);
        rd("gpio_sync2", 24'h010001, 16'h1234);
        wr(24'h010001, 16'hFFFF);
        rd("gpio_in_ro", 24'h010001, 16'h1234);
        chk("gpio_out_kept", gpio_out, 16'h00A5);
        rd("gpio_off2", 24'h010002, 16'h0000);
        wr(24'h040000, 16'hDEAD);
        rd("bank4", 24'h040000, 16'h0000);
        rd("bank_ff", 24'hFF0001, 16'h0000);
        rd("ram_untouched", 24'h000005, 16'h1234);

`ifdef CORE_MEM_FIFO_EN
        rd("fifo_stat_init", 24'h020001, 16'h0040);
        rd("fifo_data_rd", 24'h020000, 16'h0000);

        // Overfill with consumer stalled
        occ_m   = 0;
        drops_m = 0;
        for (int i = 1; i <= 10; i++) begin
            wr(24'h020000, 16'(i));
            if (occ_m < DEPTH) begin
                sb.push_back(16'(i));
                occ_m++;
            end else begin
                drops_m++;
            end
        end
        rd("fifo_stat_full", 24'h020001, {8'(drops_m), 1'b1, 1'b0, 6'(occ_m)});
        drain("fifo_drain");
        rd("fifo_stat_empty", 24'h020001, {8'(drops_m), 8'h40});

        // Clear drops, refill, then push and pop in the same cycle while full
        wr(24'h020001, 16'h0000);
        rd("fifo_drop_clr", 24'h020001, 16'h0040);
        for (int i = 0; i < DEPTH; i++) begin
            wr(24'h020000, 16'h0011 + 16'(i));
            sb.push_back(16'h0011 + 16'(i));
        end
        @(negedge clk);
        Address     = 24'h020000;
        WriteData   = 16'h7777;
        WriteEnable = 1'b1;
        out_ready   = 1'b1;
        sb.push_back(16'h7777);
        #1;
        chk("fifo_pp_head", out_data, sb.pop_front());
        @(negedge clk);
        WriteEnable = 1'b0;
        out_ready   = 1'b0;
        rd("fifo_pp_stat", 24'h020001, 16'h0088);
        drain("fifo_pp_drain");
        rd("fifo_pp_final", 24'h020001, 16'h0040);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 4; i++) wr(24'h020000, 16'hA000 + 16'(i));
        out_ready = 1'b1;
        #2;
        chk("arst_pre_valid", {15'd0, out_valid}, 16'd1);
        reset = 1'b1;
        #1;
        chk("arst_valid_drop", {15'd0, out_valid}, 16'd0);
        chk("arst_data_zero", out_data, 16'h0000);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        rd("arst_stat", 24'h020001, 16'h0040);
        chk("arst_gpio_out", gpio_out, 16'h0000);
`else
        rd("nofifo_data", 24'h020000, 16'h0000);
        rd("nofifo_stat", 24'h020001, 16'h0000);
        out_ready = 1'b1;
        wr(24'h020000, 16'h55AA);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nofifo_valid", {15'd0, out_valid}, 16'd0);
            chk("nofifo_data_out", out_data, 16'h0000);
            @(negedge clk);
        end
        out_ready = 1'b0;
        rd("nofifo_stat2", 24'h020001, 16'h0000);
`endif

        // Cycle counter: clear, then count, then cross the 16-bit boundary
        wr(24'h030000, 16'h0000);
        rd("cnt_0", 24'h030000, 16'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            rd($sformatf("cnt_%0d", k), 24'h030000, 16'(k));
        end
        wr(24'h030001, 16'h0000);
        rd("cnt_hi_ro", 24'h030000, 16'd5);
        wr(24'h030000, 16'h0000);
        repeat (65535) @(negedge clk);
        rd("cnt_lo_ffff", 24'h030000, 16'hFFFF);
        rd("cnt_hi_0", 24'h030001, 16'h0000);
        @(negedge clk);
        rd("cnt_hi_1", 24'h030001, 16'h0001);
        rd("cnt_lo_wrap", 24'h030000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
